uart_tx_word: RTL and testbench
===============================

// Module: uart_tx_word
// PURPOSE
//   8N1 UART transmitter with 32-bit word sequencing. Sits between debug_unit and the TX pin:
//   - 32-bit request: serialises one word as four consecutive bytes, least-significant byte first.
//   - 8-bit request: sends only the low byte.
//   Provides the per-byte and per-word completion pulses that debug_unit uses to pace its reports.
// PARAMETERS
//   NB_DATA       32    width of i_tx_data (must be 4*NB_BYTE)
//   NB_BYTE       8     bits per UART frame payload
//   CLKS_PER_BIT  2604  i_clock cycles per serial bit (25 MHz / 9600 baud); must be >= 2
// PORTS
//   i_clock              in   1        system clock (divided clock domain); all logic on rising edge
//   i_reset              in   1        asynchronous, active-low reset
//   i_tx_data            in   NB_DATA  payload; sampled only on an accepted start
//   i_tx_start_8b        in   1        request: send i_tx_data[7:0] as one frame
//   i_tx_start_32b       in   1        request: send all four bytes of i_tx_data
//   o_tx                 out  1        serial line, idle high
//   o_tx_busy            out  1        high while a transfer is in progress
//   o_tx_done_8b_pulse   out  1        1-cycle pulse after each byte's stop bit
//   o_tx_done_32b_pulse  out  1        1-cycle pulse after the 4th byte of a word transfer
// BEHAVIOUR
//   - Reset (i_reset low, asynchronous): state IDLE, o_tx=1, o_tx_busy=0, both done pulses 0,
//     shift/byte/bit/baud counters cleared. Reset mid-frame aborts immediately:
//     o_tx returns high and no done pulse is issued.
//   - States: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//   - Accept a start only in IDLE; a start asserted while busy is ignored, not queued.
//     If both starts are high in the same cycle, the 32b request wins.
//   - Accept cycle T: latch i_tx_data into the word register. Record mode (1 byte or 4 bytes).
//     Byte index = 0. o_tx_busy=1 from T+1.
//   - Frame timing:
//     - START drives o_tx=0 for exactly CLKS_PER_BIT cycles, beginning at T+1.
//     - DATA drives 8 bits LSB-first, CLKS_PER_BIT cycles each.
//     - STOP drives o_tx=1 for CLKS_PER_BIT cycles.
//     - One frame = 10*CLKS_PER_BIT cycles.
//   - Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when it
//     reaches CLKS_PER_BIT-1. The counter is cleared on accept and on every state change.
//   - Byte k (k=0..3) = word[8k+7:8k].
//   - End of STOP (cycle E):
//     - o_tx_done_8b_pulse=1 at E+1.
//     - If more bytes remain in 32b mode: the byte index increments and START of the next byte
//       begins at E+1 (no idle gap between frames).
//     - Otherwise: return to IDLE at E+1, o_tx_busy=0 at E+1.
//     - For the last byte of a 32b word, o_tx_done_32b_pulse=1 in the same cycle as
//       o_tx_done_8b_pulse. No 32b pulse is ever issued in 8b mode.
//   - A new start may be accepted in the same cycle that o_tx_busy falls (back-to-back words).
//   - Word latency: accept at T -> o_tx_done_32b_pulse at T + 40*CLKS_PER_BIT + 1.
//   - All outputs are registered; o_tx is glitch-free.
//   - The 2-bit byte counter never wraps past 3 in one transfer.
// TESTING (bench with CLKS_PER_BIT=4)
//   1. Reset release, no start -> o_tx=1, busy=0, no pulses for 200 cycles.
//   2. 8b start, data 0x000000A5 -> line carries 0,1,0,1,0,0,1,0,1,1 (4 cycles each);
//      one done_8b 41 cycles after accept; no done_32b.
//   3. 32b start, data 0x11223344 -> bytes 0x44,0x33,0x22,0x11 back-to-back;
//      4 done_8b pulses 40 cycles apart; done_32b coincides with the 4th, at accept+161.
//   4. Start pulses (8b and 32b) during a busy transfer, data changed mid-word
//      -> ignored; the original word is transmitted unchanged.
//   5. Both starts high together, data 0xDEADBEEF -> 4-byte transfer EF,BE,AD,DE.
//   6. Reset asserted in the 2nd byte's DATA state -> o_tx=1 and busy=0 immediately;
//      no pulses; a fresh 32b start afterwards completes normally.

Source files
------------

// File: rtl/uart_tx_word.sv
// 8N1 UART transmitter that serialises either one byte or a full 32-bit word
// (LSB byte first, frames back-to-back) and reports per-byte and per-word completion.
module uart_tx_word #(
   parameter int NB_DATA      = 32,
   parameter int NB_BYTE      = 8,
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_tx_data,
   input  logic               i_tx_start_8b,
   input  logic               i_tx_start_32b,
   output logic               o_tx,
   output logic               o_tx_busy,
   output logic               o_tx_done_8b_pulse,
   output logic               o_tx_done_32b_pulse
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(NB_BYTE);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_BYTE - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state_q;
   logic [NB_DATA-1:0]   word_q;
   logic [NB_BYTE-1:0]   shift_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic [1:0]           byte_q;
   logic                 mode32_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 done8_q;
   logic                 done32_q;

   logic                 bit_end;
   logic                 more_bytes;

   assign bit_end    = (baud_q == BAUD_LAST);
   assign more_bytes = mode32_q && (byte_q != 2'd3);

   // NOTE: every register here is updated with non-blocking assignments so all
   // next-state decisions read the values from the start of the cycle.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= IDLE;
         word_q   <= '0;
         shift_q  <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         mode32_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done8_q  <= 1'b0;
         done32_q <= 1'b0;
      end else begin
         done8_q  <= 1'b0;
         done32_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_tx_start_32b || i_tx_start_8b) begin
                  word_q   <= i_tx_data;
                  shift_q  <= i_tx_data[NB_BYTE-1:0];
                  mode32_q <= i_tx_start_32b;
                  byte_q   <= '0;
                  bit_q    <= '0;
                  baud_q   <= '0;
                  tx_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (bit_q == BIT_LAST) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_q  <= '0;
                  done8_q <= 1'b1;
                  if (more_bytes) begin
                     // The word register shifts down so the next byte always sits in its second lane.
                     byte_q  <= byte_q + 2'd1;
                     word_q  <= word_q >> NB_BYTE;
                     shift_q <= word_q[2*NB_BYTE-1:NB_BYTE];
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     done32_q <= mode32_q;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_tx                = tx_q;
   assign o_tx_busy           = busy_q;
   assign o_tx_done_8b_pulse  = done8_q;
   assign o_tx_done_32b_pulse = done32_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Self-checking bench for uart_tx_word: every cycle of each transfer is compared
// against a waveform computed arithmetically from frame position.
module tb_uart_tx_word;

   localparam int C     = 4;
   localparam int FRAME = 10 * C;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_tx_data;
   logic        i_tx_start_8b;
   logic        i_tx_start_32b;
   logic        o_tx;
   logic        o_tx_busy;
   logic        o_tx_done_8b_pulse;
   logic        o_tx_done_32b_pulse;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   uart_tx_word #(
      .NB_DATA     (32),
      .NB_BYTE     (8),
      .CLKS_PER_BIT(C)
   ) dut (
      .i_clock            (clk),
      .i_reset            (i_reset),
      .i_tx_data          (i_tx_data),
      .i_tx_start_8b      (i_tx_start_8b),
      .i_tx_start_32b     (i_tx_start_32b),
      .o_tx               (o_tx),
      .o_tx_busy          (o_tx_busy),
      .o_tx_done_8b_pulse (o_tx_done_8b_pulse),
      .o_tx_done_32b_pulse(o_tx_done_32b_pulse)
   );

   // Expected {tx, busy, done8, done32} k cycles after the accept edge.
   function automatic logic [3:0] model(input logic [31:0] w, input int nb, input int k);
      int   total;
      int   f;
      int   slot;
      logic tx;
      logic busy;
      logic d8;
      logic d32;
      total = nb * FRAME;
      tx = 1'b1; busy = 1'b0; d8 = 1'b0; d32 = 1'b0;
      if (k >= 1 && k <= total) begin
         busy = 1'b1;
         f    = (k - 1) / FRAME;
         slot = ((k - 1) % FRAME) / C;
         if (slot == 0)      tx = 1'b0;
         else if (slot <= 8) tx = w[8*f + slot - 1];
         else                tx = 1'b1;
      end
      if (k > 1 && ((k - 1) % FRAME) == 0 && ((k - 1) / FRAME) >= 1 && ((k - 1) / FRAME) <= nb)
         d8 = 1'b1;
      if (nb == 4 && k == total + 1) d32 = 1'b1;
      return {tx, busy, d8, d32};
   endfunction

   function automatic logic [3:0] observed();
      return {o_tx, o_tx_busy, o_tx_done_8b_pulse, o_tx_done_32b_pulse};
   endfunction

   // Entered and left at a negedge; the last checked cycle is idle so a new
   // start may be issued immediately (back-to-back).
   task automatic run_transfer(input string name, input logic [31:0] w, input logic s8,
                               input logic s32, input bit disturb, input int stop_k);
      int          nb;
      int          total;
      logic [3:0]  exp;
      logic [3:0]  got;
      nb    = s32 ? 4 : 1;
      total = nb * FRAME;
      i_tx_data      = w;
      i_tx_start_8b  = s8;
      i_tx_start_32b = s32;
      @(posedge clk);
      @(negedge clk);
      i_tx_start_8b  = 1'b0;
      i_tx_start_32b = 1'b0;
      for (int k = 1; k <= total + 1; k++) begin
         if (k > 1) @(negedge clk);
         exp = model(w, nb, k);
         got = observed();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s k=%0d tx/busy/d8/d32 got=%b expected=%b", name, k, got, exp);
         end
         if (k == stop_k) return;
         if (disturb) begin
            if (k == 50)  begin i_tx_start_32b = 1'b1; i_tx_data = $urandom; end
            if (k == 51)  i_tx_start_32b = 1'b0;
            if (k == 100) begin i_tx_start_8b = 1'b1; i_tx_data = $urandom; end
            if (k == 101) i_tx_start_8b = 1'b0;
            if (k == 130) begin i_tx_start_8b = 1'b1; i_tx_start_32b = 1'b1; end
            if (k == 131) begin i_tx_start_8b = 1'b0; i_tx_start_32b = 1'b0; end
         end
      end
   endtask

   task automatic idle_check(input string name, input int n);
      logic [3:0] got;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         got = observed();
         tests_run++;
         if (got !== 4'b1000) begin
            tests_failed++;
            $display("FAIL %s cycle=%0d tx/busy/d8/d32 got=%b expected=1000", name, i, got);
         end
      end
   endtask

   task automatic test_reset();
      i_tx_data      = '0;
      i_tx_start_8b  = 1'b0;
      i_tx_start_32b = 1'b0;
      i_reset        = 1'b0;
      idle_check("reset_held", 3);
      i_reset = 1'b1;
      idle_check("reset_idle", 200);
   endtask

   task automatic test_8b();
      run_transfer("8b_a5", 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 0);
      idle_check("8b_gap", 3);
      for (int i = 0; i < 3; i++) begin
         run_transfer("8b_rand", $urandom, 1'b1, 1'b0, 1'b0, 0);
         idle_check("8b_rand_gap", $urandom_range(0, 4));
      end
   endtask

   task automatic test_32b();
      run_transfer("32b_11223344", 32'h1122_3344, 1'b0, 1'b1, 1'b0, 0);
      idle_check("32b_gap", 5);
   endtask

   task automatic test_ignore_busy();
      run_transfer("busy_ignore", $urandom, 1'b0, 1'b1, 1'b1, 0);
      idle_check("busy_ignore_gap", 5);
   endtask

   task automatic test_both_starts();
      run_transfer("both_starts", 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 0);
      idle_check("both_gap", 2);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 1)
            run_transfer("b2b_32b", $urandom, 1'b0, 1'b1, 1'b0, 0);
         else
            run_transfer("b2b_8b", $urandom, 1'b1, 1'b0, 1'b0, 0);
      end
      idle_check("b2b_tail", 4);
   endtask

   task automatic test_reset_mid_frame();
      logic [3:0] got;
      // Byte 1 is 0x00, so the line is low through its DATA state at k=55.
      run_transfer("rst_pre", 32'h1234_0000, 1'b0, 1'b1, 1'b0, 55);
      i_reset = 1'b0;
      #1;
      got = observed();
      tests_run++;
      if (got !== 4'b1000) begin
         tests_failed++;
         $display("FAIL rst_abort tx/busy/d8/d32 got=%b expected=1000", got);
      end
      idle_check("rst_hold", 3);
      i_reset = 1'b1;
      idle_check("rst_after", 20);
      run_transfer("rst_fresh", $urandom, 1'b0, 1'b1, 1'b0, 0);
      idle_check("rst_fresh_gap", 3);
   endtask

   initial begin
      test_reset();
      test_8b();
      test_32b();
      test_ignore_busy();
      test_both_starts();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
